// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned OWN_W = 2;

  // Which requester was granted in the previous cycle
  localparam logic [OWN_W-1:0] OWN_NONE = 2'd0;
  localparam logic [OWN_W-1:0] OWN_INSN = 2'd1;
  localparam logic [OWN_W-1:0] OWN_DATA = 2'd2;

  localparam int unsigned STARVE_W             = 8;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-read memory:
// data port has priority, instruction port is forced through after repeated denials.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AWIDTH       = 32,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [AWIDTH-1:0] i_addr,
  output logic              i_grant,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_valid,
  input  logic              d_write,
  input  logic [3:0]        d_wmask,
  input  logic [31:0]       d_wdata,
  input  logic [AWIDTH-1:0] d_addr,
  output logic              d_grant,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_valid,
  output logic              mem_write,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] SAT   = {STARVE_W{1'b1}};

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic                force_i;

  // Grant decision, memory port steering and next-state
  always_comb begin
    force_i      = 1'b0;
    d_grant      = 1'b0;
    i_grant      = 1'b0;
    mem_valid    = 1'b0;
    mem_write    = 1'b0;
    mem_wmask    = 4'b0000;
    mem_wdata    = d_wdata;
    mem_addr     = i_addr;
    owner_d      = OWN_NONE;
    starve_cnt_d = '0;

    if (!rst) begin
      force_i = i_valid & (starve_cnt_q >= LIMIT);
      d_grant = d_valid & ~force_i;
      i_grant = i_valid & ~d_grant;
    end

    mem_valid = i_grant | d_grant;
    if (d_grant) begin
      mem_write = d_write;
      mem_wmask = d_wmask;
      mem_addr  = d_addr;
      owner_d   = OWN_DATA;
    end else if (i_grant) begin
      owner_d   = OWN_INSN;
    end

    // Count consecutive denials of a pending fetch, saturating
    if (i_valid && !i_grant) begin
      starve_cnt_d = (starve_cnt_q == SAT) ? SAT : starve_cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      owner_q      <= OWN_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
    end
  end

  // Responses are masked while reset is held so an in-flight ack is dropped
  assign i_rvalid = (owner_q == OWN_INSN) & ~rst;
  assign d_rvalid = (owner_q == OWN_DATA) & ~rst;
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule
